dm_arbiter: RTL
===============

DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter MAX_STREAK, 4: max consecutive M-port grants while loader port waits (1..15).
REQ-002 Parameter TIMEOUT, 16: max BUSY cycles awaiting mem_ack before error completion (2..255).
REQ-003 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 m_req, m_we  in  1,1  M-stage access request / write enable.
REQ-007 m_addr, m_wdata  in  32,32  M-stage byte address (bits 1:0 ignored) / store data.
REQ-008 l_req, l_we  in  1,1  loader/debug port request / write enable.
REQ-009 l_addr, l_wdata  in  32,32  loader byte address (bits 1:0 ignored) / store data.
REQ-010 m_done, m_err, m_rdata  out  1,1,32  M completion pulse, error flag, load data.
REQ-011 l_done, l_err, l_rdata  out  1,1,32  loader completion pulse, error flag, load data.
REQ-012 m_stall  out  1  combinational m_req & ~m_done; freezes M/W pipeline registers.
REQ-013 mem_req, mem_we  out  1,1  data-memory request / write enable, registered.
REQ-014 mem_addr, mem_wdata  out  32,32  word address {addr[31:2],2'b00} / store data, registered.
REQ-015 mem_rdata, mem_ack  in  32,1  memory read data; ack valid with rdata, one cycle.
REQ-016 busy  out  1  high whenever FSM is not IDLE.

Function
REQ-017 FSM SHALL have states IDLE, BUSY, DONE.
REQ-018 IDLE: if any req, grant one port, latch its we/addr/wdata, go BUSY; else stay.
REQ-019 Grant rule: M wins unless l_req=1 and streak counter == MAX_STREAK; loader wins if m_req=0.
REQ-020 Streak counter SHALL increment on each M grant while l_req=1, clear on any loader grant or when l_req=0, saturate at MAX_STREAK.
REQ-021 mem_req SHALL be 1 throughout BUSY with latched fields stable; 0 in IDLE and DONE.
REQ-022 BUSY: mem_ack=1 -> capture mem_rdata (loads), go DONE, err=0.
REQ-023 BUSY: timeout counter reaches TIMEOUT with no ack -> go DONE, err=1, rdata=32'h0.
REQ-024 Ack and timeout in same cycle: ack wins, err=0.
REQ-025 DONE: assert granted port's done for exactly one cycle with rdata/err; go IDLE.
REQ-026 rdata/err SHALL hold last value until that port's next done; stores return rdata unchanged.
REQ-027 Minimum latency: req sampled cycle n -> mem_req cycle n+1 -> zero-wait ack cycle n+1 -> done cycle n+2.
REQ-028 Requester input changes after grant SHALL be ignored; dropping req mid-transaction still yields done.
REQ-029 mem_ack outside BUSY SHALL be ignored.
REQ-030 Never more than one outstanding memory transaction; done SHALL never pulse on both ports in one cycle.

Reset
REQ-031 reset=0 SHALL immediately force IDLE, mem_req=0, mem_we=0, all done=0, err=0, busy=0, counters=0, rdata=0, mem_addr=0, mem_wdata=0.
REQ-032 Reset mid-BUSY SHALL abandon the transaction with no done pulse; first grant after release is fresh arbitration.

Verification
REQ-033 m_req load addr 0x0000_0013, ack next cycle rdata 0x1234_5678 -> mem_addr 0x10, m_done at n+2, m_rdata 0x1234_5678, m_stall high n..n+1.
REQ-034 m_req and l_req held continuously, zero-wait memory, MAX_STREAK=4 -> grant order M,M,M,M,L,M,M,M,M,L.
REQ-035 Loader store, mem_ack never asserted, TIMEOUT=16 -> mem_req high 16 cycles, l_done with l_err=1, l_rdata 0.
REQ-036 Ack arrives on cycle TIMEOUT exactly -> done with err=0, data captured.
REQ-037 Reset asserted in BUSY, ack pulsed after release while IDLE -> no done, mem_req 0, ack ignored.
REQ-038 M changes m_addr 0x40->0x80 mid-BUSY -> mem_addr stays 0x40 until done.

Source files
------------

// File: rtl/dm_arbiter.sv
`timescale 1ns/1ps
// Data-memory arbiter: the M-stage port normally wins, and the loader port is granted
// after a bounded streak of M wins. One memory transaction is outstanding at a time.
module dm_arbiter #(
  parameter int MAX_STREAK = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m_req,
  input  logic        m_we,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_wdata,
  input  logic        l_req,
  input  logic        l_we,
  input  logic [31:0] l_addr,
  input  logic [31:0] l_wdata,
  output logic        m_done,
  output logic        m_err,
  output logic [31:0] m_rdata,
  output logic        l_done,
  output logic        l_err,
  output logic [31:0] l_rdata,
  output logic        m_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        busy
);

  localparam logic [3:0] STREAK_LIM = 4'(MAX_STREAK);
  localparam logic [7:0] TO_LAST    = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        sel_l_q, sel_l_d;
  logic [3:0]  streak_q, streak_d;
  logic [7:0]  tcnt_q, tcnt_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic [31:0] m_rdata_q, m_rdata_d;
  logic [31:0] l_rdata_q, l_rdata_d;
  logic        m_err_q, m_err_d;
  logic        l_err_q, l_err_d;
  logic        grant_l;

  assign grant_l = l_req & (~m_req | (streak_q == STREAK_LIM));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      sel_l_q     <= 1'b0;
      streak_q    <= '0;
      tcnt_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      m_rdata_q   <= '0;
      l_rdata_q   <= '0;
      m_err_q     <= 1'b0;
      l_err_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_l_q     <= sel_l_d;
      streak_q    <= streak_d;
      tcnt_q      <= tcnt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      m_rdata_q   <= m_rdata_d;
      l_rdata_q   <= l_rdata_d;
      m_err_q     <= m_err_d;
      l_err_q     <= l_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sel_l_d     = sel_l_q;
    streak_d    = streak_q;
    tcnt_d      = tcnt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    m_rdata_d   = m_rdata_q;
    l_rdata_d   = l_rdata_q;
    m_err_d     = m_err_q;
    l_err_d     = l_err_q;

    // The streak only measures how long the loader has been kept waiting.
    if (!l_req) streak_d = '0;

    case (state_q)
      IDLE: begin
        if (m_req | l_req) begin
          state_d   = BUSY;
          sel_l_d   = grant_l;
          tcnt_d    = '0;
          mem_req_d = 1'b1;
          if (grant_l) begin
            mem_we_d    = l_we;
            mem_addr_d  = l_addr & 32'hFFFF_FFFC;
            mem_wdata_d = l_wdata;
            streak_d    = '0;
          end else begin
            mem_we_d    = m_we;
            mem_addr_d  = m_addr & 32'hFFFF_FFFC;
            mem_wdata_d = m_wdata;
            if (l_req) streak_d = (streak_q == STREAK_LIM) ? streak_q : streak_q + 4'd1;
          end
        end
      end
      BUSY: begin
        // An ack on the final allowed cycle still completes without error.
        if (mem_ack || (tcnt_q == TO_LAST)) begin
          state_d   = DONE;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (sel_l_q) begin
            l_err_d = ~mem_ack;
            if (!mem_ack)      l_rdata_d = '0;
            else if (!mem_we_q) l_rdata_d = mem_rdata;
          end else begin
            m_err_d = ~mem_ack;
            if (!mem_ack)      m_rdata_d = '0;
            else if (!mem_we_q) m_rdata_d = mem_rdata;
          end
        end else begin
          tcnt_d = tcnt_q + 8'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign m_done    = (state_q == DONE) & ~sel_l_q;
  assign l_done    = (state_q == DONE) &  sel_l_q;
  assign m_err     = m_err_q;
  assign l_err     = l_err_q;
  assign m_rdata   = m_rdata_q;
  assign l_rdata   = l_rdata_q;
  assign m_stall   = m_req & ~m_done;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = (state_q != IDLE);

endmodule
